// File: rtl/receive_data.sv
// rtl/receive_data.sv - assembles four FIFO bytes LSB-first into a 32-bit word with per-byte timeout
module receive_data #(
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        fifo_empty,
    input  logic [7:0]  in,
    output logic        req_rd,
    output logic [31:0] data_out,
    output logic        done,
    output logic        error,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_READ,
        S_LATCH,
        S_DONE,
        S_ERR
    } state_t;

    // Last tolerated empty-cycle count before the byte wait is abandoned.
    localparam logic [15:0] TMO_LAST = TIMEOUT - 16'd1;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_shift;
    logic [31:0] w_shift_next;
    logic [31:0] r_data;
    logic [31:0] w_data_next;
    logic [2:0]  r_cnt;
    logic [2:0]  w_cnt_next;
    logic [15:0] r_tmo;
    logic [15:0] w_tmo_next;
    logic        r_req_rd;
    logic        w_req_rd_next;
    logic        r_done;
    logic        w_done_next;
    logic        r_error;
    logic        w_error_next;
    logic        r_busy;

    assign req_rd   = r_req_rd;
    assign data_out = r_data;
    assign done     = r_done;
    assign error    = r_error;
    assign busy     = r_busy;

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        w_next_state  = r_state;
        w_shift_next  = r_shift;
        w_data_next   = r_data;
        w_cnt_next    = r_cnt;
        w_tmo_next    = r_tmo;
        w_req_rd_next = 1'b0;
        w_done_next   = 1'b0;
        w_error_next  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_cnt_next   = 3'd0;
                    w_shift_next = 32'd0;
                    w_tmo_next   = 16'd0;
                    w_next_state = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!fifo_empty) begin
                    w_req_rd_next = 1'b1;
                    w_tmo_next    = 16'd0;
                    w_next_state  = S_READ;
                end else if (r_tmo == TMO_LAST) begin
                    w_next_state = S_ERR;
                end else begin
                    w_tmo_next = r_tmo + 16'd1;
                end
            end
            S_READ: begin
                // The FIFO presents the byte during the following cycle.
                w_next_state = S_LATCH;
            end
            S_LATCH: begin
                w_shift_next = {in, r_shift[31:8]};
                w_cnt_next   = r_cnt + 3'd1;
                if (r_cnt == 3'd3) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_CHECK;
                end
            end
            S_DONE: begin
                w_data_next  = r_shift;
                w_done_next  = 1'b1;
                w_next_state = S_IDLE;
            end
            S_ERR: begin
                // Partial bytes stay in r_shift and are wiped by the next start.
                w_done_next  = 1'b1;
                w_error_next = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State, datapath and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_shift  <= 32'd0;
            r_data   <= 32'd0;
            r_cnt    <= 3'd0;
            r_tmo    <= 16'd0;
            r_req_rd <= 1'b0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_shift  <= w_shift_next;
            r_data   <= w_data_next;
            r_cnt    <= w_cnt_next;
            r_tmo    <= w_tmo_next;
            r_req_rd <= w_req_rd_next;
            r_done   <= w_done_next;
            r_error  <= w_error_next;
            r_busy   <= (w_next_state != S_IDLE);
        end
    end

endmodule

// File: tb/tb_receive_data.sv
// tb/tb_receive_data.sv - self-checking bench for receive_data with a transaction-level byte model
module tb_receive_data;

    localparam logic [15:0] TMO = 16'd8;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [7:0]  in = 8'd0;
    logic        req_rd;
    logic [31:0] data_out;
    logic        done;
    logic        error;
    logic        busy;

    receive_data #(.TIMEOUT(TMO)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .fifo_empty (fifo_empty),
        .in         (in),
        .req_rd     (req_rd),
        .data_out   (data_out),
        .done       (done),
        .error      (error),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    logic [7:0] q[$];
    logic [7:0] mq[$];
    int vectors = 0;
    int miscompares = 0;
    int ecyc = 0;
    int gap_s = 0;
    int gap_l = 0;
    int rd_cnt = 0;
    int c;
    int dcount;

    bit          m_valid = 1'b0;
    bit          m_act = 1'b0;
    int          m_nb, m_tc, m_lat, m_end;
    logic [7:0]  m_b[4];
    logic [7:0]  m_pend;
    logic        exp_rd, exp_done, exp_err, exp_busy;
    logic [31:0] exp_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Byte-level model: each byte costs one FIFO-not-empty poll plus two cycles of read latency.
    task automatic model(input bit s, input bit e, input bit r);
        exp_rd   = 1'b0;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        m_valid  = 1'b1;
        if (!r) begin
            m_act    = 1'b0;
            exp_data = 32'd0;
        end else if (!m_act) begin
            if (s) begin
                m_act = 1'b1; m_nb = 0; m_tc = 0; m_lat = 0; m_end = 0;
            end
        end else if (m_end == 1) begin
            exp_done = 1'b1;
            exp_data = {m_b[3], m_b[2], m_b[1], m_b[0]};
            m_act    = 1'b0;
        end else if (m_end == 2) begin
            exp_done = 1'b1;
            exp_err  = 1'b1;
            m_act    = 1'b0;
        end else if (m_lat > 0) begin
            m_lat--;
            if (m_lat == 0) begin
                m_b[m_nb] = m_pend;
                m_nb++;
                if (m_nb == 4) m_end = 1;
            end
        end else if (!e) begin
            exp_rd = 1'b1;
            m_pend = (mq.size() > 0) ? mq.pop_front() : 8'hxx;
            m_lat  = 2;
            m_tc   = 0;
        end else if (m_tc == int'(TMO) - 1) begin
            m_end = 2;
        end else begin
            m_tc++;
        end
        exp_busy = m_act;
    endtask

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clock) begin
        if (m_valid) begin
            chk("req_rd", {31'd0, req_rd}, {31'd0, exp_rd});
            chk("done", {31'd0, done}, {31'd0, exp_done});
            chk("error", {31'd0, error}, {31'd0, exp_err});
            chk("busy", {31'd0, busy}, {31'd0, exp_busy});
            chk("data_out", data_out, exp_data);
        end
    end

    task automatic upd_empty();
        fifo_empty = (q.size() == 0) || ((ecyc + 1 >= gap_s) && (ecyc + 1 < gap_s + gap_l));
    endtask

    task automatic push(input logic [7:0] b);
        q.push_back(b);
        mq.push_back(b);
        upd_empty();
    endtask

    task automatic step();
        bit s, e, r, rd;
        s  = start;
        e  = fifo_empty;
        r  = reset;
        rd = req_rd;
        @(posedge clock);
        #1;
        model(s, e, r);
        if (rd) begin
            if (q.size() > 0) in = q.pop_front();
            rd_cnt++;
        end
        ecyc++;
        upd_empty();
    endtask

    task automatic kick(input bit hold);
        rd_cnt = 0;
        start  = 1'b1;
        step();
        ecyc = 0;
        if (!hold) start = 1'b0;
        upd_empty();
    endtask

    task automatic run_done(input int maxc, output int cyc);
        cyc = -1;
        for (int i = 0; i < maxc; i++) begin
            step();
            if (done === 1'b1) begin
                cyc = ecyc;
                break;
            end
        end
        if (cyc < 0) begin
            vectors++;
            miscompares++;
            $display("FAIL done_wait: no done within %0d cycles", maxc);
        end
    endtask

    initial begin
        // Reset state.
        step();
        step();
        reset = 1'b1;
        step();
        chk("rst_data", data_out, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_req_rd", {31'd0, req_rd}, 32'd0);

        // Four bytes always available.
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        kick(1'b0);
        run_done(40, c);
        chk("t1_latency", c, 13);
        chk("t1_data", data_out, 32'h44332211);
        chk("t1_error", {31'd0, error}, 32'd0);
        chk("t1_rd_pulses", rd_cnt, 4);
        step();

        // Five-cycle empty gap before the third byte.
        gap_s = 7;
        gap_l = 5;
        push(8'h55); push(8'h66); push(8'h77); push(8'h88);
        kick(1'b0);
        run_done(40, c);
        chk("t2_latency", c, 18);
        chk("t2_data", data_out, 32'h88776655);
        gap_l = 0;
        step();

        // Only two bytes: timeout abort keeps the previous word.
        push(8'hAA); push(8'hBB);
        kick(1'b0);
        run_done(40, c);
        chk("t3_latency", c, 15);
        chk("t3_error", {31'd0, error}, 32'd1);
        chk("t3_data_kept", data_out, 32'h88776655);
        step();
        chk("t3_busy_after", {31'd0, busy}, 32'd0);
        chk("t3_done_after", {31'd0, done}, 32'd0);

        // Reset one cycle after the second byte lands, then a clean transaction.
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        kick(1'b0);
        repeat (6) step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        q.delete();
        mq.delete();
        upd_empty();
        chk("t4_rst_data", data_out, 32'd0);
        chk("t4_rst_busy", {31'd0, busy}, 32'd0);
        push(8'hA1); push(8'hB2); push(8'hC3); push(8'hD4);
        kick(1'b0);
        run_done(40, c);
        chk("t4_latency", c, 13);
        chk("t4_data", data_out, 32'hD4C3B2A1);
        step();

        // Start held high: back-to-back words with one idle cycle between.
        for (int i = 1; i <= 8; i++) push(8'(i));
        kick(1'b1);
        run_done(40, c);
        chk("t5_first_latency", c, 13);
        chk("t5_first_data", data_out, 32'h04030201);
        run_done(40, c);
        start = 1'b0;
        chk("t5_second_latency", c, 27);
        chk("t5_second_data", data_out, 32'h08070605);
        step();
        step();
        chk("t5_busy_end", {31'd0, busy}, 32'd0);

        // Start pulsed while busy is ignored.
        push(8'h5A); push(8'h6B); push(8'h7C); push(8'h8D);
        kick(1'b0);
        step();
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        run_done(40, c);
        chk("t6_latency", c, 13);
        chk("t6_data", data_out, 32'h8D7C6B5A);
        dcount = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done === 1'b1) dcount++;
        end
        chk("t6_extra_done", dcount, 0);
        chk("t6_busy_end", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/receive_data.md
RECEIVE_DATA -- requirements
Module: receive_data

Interface
REQ-001 Parameter TIMEOUT, default 16'd50000: consecutive fifo_empty cycles tolerated while awaiting one byte before abort.
REQ-002 clock  input  1  single system clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 start  input  1  request to assemble one 32-bit word; sampled only in IDLE.
REQ-005 fifo_empty  input  1  high when the source FIFO holds no byte.
REQ-006 in  input  8  FIFO read data, valid the cycle after a req_rd cycle (1-cycle read latency).
REQ-007 req_rd  output  1  registered FIFO read strobe, one cycle per byte.
REQ-008 data_out  output  32  last successfully assembled word.
REQ-009 done  output  1  one-cycle pulse at end of every transaction, success or abort.
REQ-010 error  output  1  one-cycle pulse, coincident with done, on timeout abort.
REQ-011 busy  output  1  high whenever state is not IDLE.

Function
REQ-012 FSM states shall be IDLE, CHECK, READ, LATCH, DONE, ERR; all outputs registered.
REQ-013 IDLE: done, error, req_rd low; on start=1 clear byte count, shift register and timeout counter, go CHECK; otherwise stay.
REQ-014 CHECK: if fifo_empty=0, set req_rd=1, clear timeout counter, go READ; else increment timeout counter.
REQ-015 CHECK: if fifo_empty=1 and timeout counter = TIMEOUT-1, go ERR without asserting req_rd.
REQ-016 READ: req_rd=0, go LATCH (req_rd high exactly one cycle, never in two consecutive cycles).
REQ-017 LATCH: shift_reg <= {in, shift_reg[31:8]}, byte count +1; go DONE if this was byte 4, else CHECK.
REQ-018 Byte order LSB-first: first byte read lands in data_out[7:0], fourth in data_out[31:24].
REQ-019 DONE: data_out <= shift_reg, done=1 one cycle, go IDLE.
REQ-020 ERR: done=1 and error=1 one cycle, data_out unchanged, partial bytes discarded, go IDLE.
REQ-021 req_rd shall never assert while fifo_empty=1 was sampled in the same CHECK cycle (no underflow).
REQ-022 start while busy=1 shall be ignored; no queuing.
REQ-023 Latency with FIFO never empty: 3 cycles per byte; done high in the cycle after the 13th rising edge following the edge that sampled start.
REQ-024 Each empty cycle in CHECK shall add exactly one cycle of latency; the timeout counter restarts per byte.
REQ-025 start held high shall yield back-to-back transactions, one IDLE cycle between them.
REQ-026 Timeout counter width shall be 16 bits; TIMEOUT >= 1.

Reset
REQ-027 When reset=0 at a rising edge: state IDLE, req_rd=0, done=0, error=0, busy=0, data_out=0, shift_reg=0, byte count=0, timeout counter=0.
REQ-028 Reset mid-transaction shall discard partial data with no done pulse; the next start after reset release shall behave as from power-up.

Verification
REQ-029 FIFO preloaded 0x11,0x22,0x33,0x44, pulse start -> four one-cycle req_rd pulses, data_out=0x44332211, done 13 cycles after start, error=0.
REQ-030 fifo_empty=1 for 5 cycles between bytes 2 and 3 -> no req_rd during gap, done 18 cycles after start, data_out correct.
REQ-031 TIMEOUT=8, only 2 bytes available -> 8 empty CHECK cycles, done=error=1 one cycle, data_out keeps prior value, busy=0 next cycle.
REQ-032 reset=0 one cycle after byte 2 latched -> all outputs 0; new transaction with 0xA1,0xB2,0xC3,0xD4 -> data_out=0xD4C3B2A1.
REQ-033 start held high, 8 bytes 0x01..0x08 queued -> two done pulses, data_out=0x04030201 then 0x08070605.
REQ-034 start pulsed while busy -> ignored; exactly one done pulse per accepted start.
